// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared types for the memory-access stage.
//   state_t    : stage FSM states (IDLE, ACCESS, WAIT_RD, RESP)
//   op_kind_t  : classification of the accepted op (ALU, LOAD, STORE)
//   FLAG_*     : bit positions of {N,Z,V,C} inside the 4-bit flags word
//   decode_kind: maps the mem_read/mem_write pair to an op kind; a store
//                wins when both are set.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_kind_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  function automatic op_kind_t decode_kind(input logic rd, input logic wr);
    if (wr) return OP_STORE;
    if (rd) return OP_LOAD;
    return OP_ALU;
  endfunction

endpackage

// File: rtl/mem_access_stage_vlane_buffer.sv
// vlane_buffer
//   VECTOR_WIDTH x WIDTH register file used to assemble vector load data
//   one lane at a time. All lanes are read in parallel.
//   clk, rst : clock, synchronous active-high reset (clears every lane)
//   we       : write enable for the lane selected by lane
//   lane     : lane index to write
//   wdata    : data written into the selected lane
//   rdata    : all lanes concatenated, lane 0 in the least-significant slice
module vlane_buffer #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8,
  parameter int LW           = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [LW-1:0]                 lane,
  input  logic [WIDTH-1:0]              wdata,
  output logic [VECTOR_WIDTH*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] lanes [VECTOR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VECTOR_WIDTH; i++) lanes[i] <= '0;
    end else if (we) begin
      lanes[lane] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < VECTOR_WIDTH; i++) rdata[i*WIDTH +: WIDTH] = lanes[i];
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Pipeline stage after Execute. Passes ALU results through, or performs a
//   scalar / VECTOR_WIDTH-lane load or store serialized over one single-word
//   synchronous RAM port, then emits a one-cycle valid_o pulse to Writeback.
//
//   Handshake: an op is accepted on a rising edge where valid_i && ready_o.
//   ready_o is high only in IDLE and RESP; while it is low the op inputs are
//   ignored and upstream must hold them. valid_o is high for exactly the one
//   RESP cycle of each op and carries no back-pressure.
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     valid_i / ready_o         Execute handshake
//     is_vector_i, mem_read_i, mem_write_i, reg_write_i, rd_i,
//     alu_result_i, store_data_i, vec_result_i, flags_i   op fields
//     mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o          RAM port (registered)
//     mem_rdata_i               RAM read data, one cycle after mem_re_o
//     valid_o, reg_write_o, is_vector_o, rd_o, flags_o,
//     result_o, vec_result_o, err_o                        Writeback result
//     state_o                   current FSM state, for observation
//
//   Build option: VMEM_ALIGN_CHECK_EN -- when defined, a vector memory op
//   whose base address is not a multiple of VECTOR_WIDTH performs no RAM
//   access and responds with err_o=1, reg_write_o=0, vec_result_o=0.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int REG_AW       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          is_vector_i,
  input  logic                          mem_read_i,
  input  logic                          mem_write_i,
  input  logic                          reg_write_i,
  input  logic [REG_AW-1:0]             rd_i,
  input  logic [WIDTH-1:0]              alu_result_i,
  input  logic [WIDTH-1:0]              store_data_i,
  input  logic [VECTOR_WIDTH*WIDTH-1:0] vec_result_i,
  input  logic [3:0]                    flags_i,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]              mem_wdata_o,
  output logic                          mem_we_o,
  output logic                          mem_re_o,
  input  logic [WIDTH-1:0]              mem_rdata_i,
  output logic                          valid_o,
  output logic                          reg_write_o,
  output logic                          is_vector_o,
  output logic [REG_AW-1:0]             rd_o,
  output logic [3:0]                    flags_o,
  output logic [WIDTH-1:0]              result_o,
  output logic [VECTOR_WIDTH*WIDTH-1:0] vec_result_o,
  output logic                          err_o,
  output state_t                        state_o
);

  localparam int LW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int VB = VECTOR_WIDTH * WIDTH;

  state_t            state_q;
  op_kind_t          kind_q;
  logic              vec_q;
  logic              rw_q;
  logic [REG_AW-1:0] rd_q;
  logic [3:0]        flags_q;
  logic [WIDTH-1:0]  alu_q;
  logic [VB-1:0]     vdata_q;
  logic              err_q;
  logic [LW-1:0]     lane_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              we_q;
  logic              re_q;
  // Read data returns one cycle after the request; these remember which
  // lane the returning word belongs to.
  logic              cap_en_q;
  logic [LW-1:0]     cap_lane_q;

  logic          accept;
  op_kind_t      acc_kind;
  logic          misalign;
  logic [LW-1:0] last_lane;
  logic [LW-1:0] lane_next;
  logic [VB-1:0] buf_data;

  assign ready_o   = (state_q == IDLE) || (state_q == RESP);
  assign accept    = valid_i && ready_o;
  assign acc_kind  = decode_kind(mem_read_i, mem_write_i);
  assign last_lane = vec_q ? LW'(VECTOR_WIDTH - 1) : '0;
  assign lane_next = lane_q + LW'(1);

`ifdef VMEM_ALIGN_CHECK_EN
  assign misalign = is_vector_i && (acc_kind != OP_ALU) &&
                    ((alu_result_i[ADDR_WIDTH-1:0] % ADDR_WIDTH'(VECTOR_WIDTH)) != '0);
`else
  assign misalign = 1'b0;
`endif

  vlane_buffer #(
    .WIDTH        (WIDTH),
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .LW           (LW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (cap_en_q),
    .lane  (cap_lane_q),
    .wdata (mem_rdata_i),
    .rdata (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kind_q     <= OP_ALU;
      vec_q      <= 1'b0;
      rw_q       <= 1'b0;
      rd_q       <= '0;
      flags_q    <= '0;
      alu_q      <= '0;
      vdata_q    <= '0;
      err_q      <= 1'b0;
      lane_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cap_en_q   <= 1'b0;
      cap_lane_q <= '0;
    end else begin
      cap_en_q   <= re_q;
      cap_lane_q <= lane_q;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            kind_q  <= acc_kind;
            vec_q   <= is_vector_i;
            rw_q    <= reg_write_i;
            rd_q    <= rd_i;
            flags_q <= flags_i;
            alu_q   <= alu_result_i;
            vdata_q <= vec_result_i;
            err_q   <= misalign;
            lane_q  <= '0;
            addr_q  <= alu_result_i[ADDR_WIDTH-1:0];
            wdata_q <= is_vector_i ? vec_result_i[WIDTH-1:0] : store_data_i;
            if (acc_kind == OP_ALU || misalign) begin
              state_q <= RESP;
            end else begin
              state_q <= ACCESS;
              we_q    <= (acc_kind == OP_STORE);
              re_q    <= (acc_kind == OP_LOAD);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (lane_q == last_lane) begin
            state_q <= (kind_q == OP_LOAD) ? WAIT_RD : RESP;
          end else begin
            lane_q  <= lane_next;
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            wdata_q <= vdata_q[lane_next*WIDTH +: WIDTH];
            we_q    <= (kind_q == OP_STORE);
            re_q    <= (kind_q == OP_LOAD);
          end
        end
        WAIT_RD: state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;
  assign mem_re_o    = re_q;
  assign state_o     = state_q;

  assign valid_o     = (state_q == RESP);
  assign err_o       = valid_o && err_q;
  assign reg_write_o = valid_o && rw_q && !err_q;
  assign is_vector_o = valid_o && vec_q;
  assign rd_o        = valid_o ? rd_q : '0;
  assign flags_o     = valid_o ? flags_q : '0;

  always_comb begin
    result_o     = '0;
    vec_result_o = '0;
    if (valid_o && !err_q) begin
      case (kind_q)
        OP_ALU: begin
          result_o = alu_q;
          if (vec_q) vec_result_o = vdata_q;
        end
        OP_LOAD: begin
          if (vec_q) vec_result_o = buf_data;
          else       result_o     = buf_data[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Bench for mem_access_stage with a synchronous single-port RAM model.
//   Build option VMEM_ALIGN_CHECK_EN selects the misaligned-vector scenario
//   instead of the address-wrap store scenario.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int W   = 24;
  localparam int VWN = 8;
  localparam int AW  = 16;
  localparam int RAW = 4;
  localparam int VB  = VWN * W;

  logic           clk, rst, valid_i, ready_o;
  logic           is_vector_i, mem_read_i, mem_write_i, reg_write_i;
  logic [RAW-1:0] rd_i, rd_o;
  logic [W-1:0]   alu_result_i, store_data_i, mem_wdata_o, mem_rdata_i, result_o;
  logic [VB-1:0]  vec_result_i, vec_result_o;
  logic [3:0]     flags_i, flags_o;
  logic [AW-1:0]  mem_addr_o;
  logic           mem_we_o, mem_re_o, valid_o, reg_write_o, is_vector_o, err_o;
  state_t         state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0]  exp_q[$];
  logic [VB-1:0] exp_vq[$];
  logic [RAW-1:0] cur_rd;
  logic [3:0]     cur_fl;
  logic           cur_vec;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .is_vector_i(is_vector_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .reg_write_i(reg_write_i), .rd_i(rd_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .vec_result_i(vec_result_i), .flags_i(flags_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .is_vector_o(is_vector_o), .rd_o(rd_o),
    .flags_o(flags_o), .result_o(result_o), .vec_result_o(vec_result_o),
    .err_o(err_o), .state_o(state_o)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- RAM model + access logs ----------------
  logic [W-1:0]  ram [0:65535];
  logic [W-1:0]  rdata_r = '0;
  logic [AW-1:0] wr_log [0:255];
  logic [AW-1:0] rd_log [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (mem_we_o) begin
      ram[mem_addr_o]    <= mem_wdata_o;
      wr_log[wr_cnt%256] <= mem_addr_o;
      wr_cnt             <= wr_cnt + 1;
    end
    if (mem_re_o) begin
      rdata_r            <= ram[mem_addr_o];
      rd_log[rd_cnt%256] <= mem_addr_o;
      rd_cnt             <= rd_cnt + 1;
    end
  end
  assign mem_rdata_i = rdata_r;

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_op(input logic vec, input logic rd, input logic wr, input logic rw,
                         input logic [RAW-1:0] rdi, input logic [W-1:0] alu,
                         input logic [W-1:0] sd, input logic [VB-1:0] vres,
                         input logic [3:0] fl);
    @(posedge clk); #1;
    is_vector_i = vec; mem_read_i = rd; mem_write_i = wr; reg_write_i = rw;
    rd_i = rdi; alu_result_i = alu; store_data_i = sd; vec_result_i = vres;
    flags_i = fl; valid_i = 1'b1;
    cur_rd = rdi; cur_fl = fl; cur_vec = vec;
    @(negedge clk);
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept_ready: ready_o=%b required 1", ready_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Waits for valid_o after an accept and pops the scoreboard.
  task automatic wait_resp(input string name, input int exp_lat, input bit chk_res,
                           input bit chk_vec, input logic exp_rw, input logic exp_err);
    int lat = 0;
    bit seen = 0;
    bit busy_bad = 0;
    logic [W-1:0]  er;
    logic [VB-1:0] ev;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (valid_o === 1'b1) seen = 1;
      else if (ready_o !== 1'b0) busy_bad = 1;
    end
    er = exp_q.pop_front();
    ev = exp_vq.pop_front();
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s timeout: no valid_o within %0d cycles", name, lat);
    end else begin
      tests_run++;
      if (lat !== exp_lat) begin
        tests_failed++;
        $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
      end
      tests_run++;
      if (busy_bad) begin
        tests_failed++;
        $display("FAIL %s ready_busy: ready_o high while access in flight", name);
      end
      if (chk_res) begin
        tests_run++;
        if (result_o !== er) begin
          tests_failed++;
          $display("FAIL %s result: got %h required %h", name, result_o, er);
        end
      end
      if (chk_vec) begin
        tests_run++;
        if (vec_result_o !== ev) begin
          tests_failed++;
          $display("FAIL %s vec_result: got %h required %h", name, vec_result_o, ev);
        end
      end
      tests_run++;
      if (reg_write_o !== exp_rw || err_o !== exp_err) begin
        tests_failed++;
        $display("FAIL %s rw_err: got rw=%b err=%b required rw=%b err=%b",
                 name, reg_write_o, err_o, exp_rw, exp_err);
      end
      tests_run++;
      if (rd_o !== cur_rd || flags_o !== cur_fl || is_vector_o !== cur_vec) begin
        tests_failed++;
        $display("FAIL %s fields: got rd=%h fl=%h vec=%b required rd=%h fl=%h vec=%b",
                 name, rd_o, flags_o, is_vector_o, cur_rd, cur_fl, cur_vec);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || state_o !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready=%b valid=%b state=%0d required 1 0 0",
               ready_o, valid_o, state_o);
    end
    tests_run++;
    if (mem_we_o !== 1'b0 || mem_re_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem: we=%b re=%b addr=%h wdata=%h required all 0",
               mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o);
    end
    tests_run++;
    if (result_o !== '0 || vec_result_o !== '0 || err_o !== 1'b0 || reg_write_o !== 1'b0 ||
        rd_o !== '0 || flags_o !== '0 || is_vector_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: result=%h err=%b rw=%b rd=%h fl=%h required all 0",
               result_o, err_o, reg_write_o, rd_o, flags_o);
    end
  endtask

  task automatic test_alu_back_to_back();
    logic [W-1:0] er;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      is_vector_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b1;
      rd_i = RAW'(k + 1); alu_result_i = 24'h00ABCD; flags_i = 4'(k * 5 + 2);
      valid_i = 1'b1;
      exp_q.push_back(24'h00ABCD);
      @(posedge clk); #1;
      if (k == 3) valid_i = 1'b0;
      @(negedge clk);
      er = exp_q.pop_front();
      tests_run++;
      if (valid_o !== 1'b1 || ready_o !== 1'b1 || result_o !== er) begin
        tests_failed++;
        $display("FAIL b2b_%0d: valid=%b ready=%b result=%h required 1 1 %h",
                 k, valid_o, ready_o, result_o, er);
      end
      tests_run++;
      if (rd_o !== RAW'(k + 1) || flags_o !== 4'(k * 5 + 2) || reg_write_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_fields_%0d: rd=%h fl=%h rw=%b required %h %h 1",
                 k, rd_o, flags_o, reg_write_o, RAW'(k + 1), 4'(k * 5 + 2));
      end
    end
    @(negedge clk);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: valid_o=%b required 0", valid_o);
    end
  endtask

  task automatic test_vector_alu();
    logic [VB-1:0] v;
    for (int i = 0; i < VWN; i++) v[i*W +: W] = W'($urandom_range(0, 24'hFFFFFF));
    exp_q.push_back(24'h13579B);
    exp_vq.push_back(v);
    send_op(1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 24'h13579B, '0, v, 4'b1010);
    wait_resp("vec_alu", 1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_scalar_store();
    int w0 = wr_cnt;
    exp_q.push_back('0);
    exp_vq.push_back('0);
    send_op(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 24'h000010, 24'h123456, '0, 4'b0001);
    wait_resp("s_store", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (wr_cnt - w0 != 1 || wr_log[w0%256] !== 16'h0010 || ram[16'h0010] !== 24'h123456) begin
      tests_failed++;
      $display("FAIL s_store_mem: writes=%0d addr=%h data=%h required 1 0010 123456",
               wr_cnt - w0, wr_log[w0%256], ram[16'h0010]);
    end
  endtask

  task automatic test_scalar_load();
    int r0;
    preload(16'h0100, 24'h5A5A5A);
    r0 = rd_cnt;
    exp_q.push_back(24'h5A5A5A);
    exp_vq.push_back('0);
    send_op(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 24'h000100, '0, '0, 4'b0100);
    wait_resp("s_load", 3, 1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (rd_cnt - r0 != 1 || rd_log[r0%256] !== 16'h0100) begin
      tests_failed++;
      $display("FAIL s_load_mem: reads=%0d addr=%h required 1 0100", rd_cnt - r0, rd_log[r0%256]);
    end
  endtask

  task automatic test_vector_load();
    logic [VB-1:0] ev;
    int r0;
    bit bad = 0;
    for (int i = 0; i < VWN; i++) begin
      preload(AW'(16'h0040 + i), W'(i * 3));
      ev[i*W +: W] = W'(i * 3);
    end
    r0 = rd_cnt;
    exp_q.push_back('0);
    exp_vq.push_back(ev);
    send_op(1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 24'h000040, '0, '0, 4'b1000);
    wait_resp("v_load", 10, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < VWN; i++) if (rd_log[(r0 + i)%256] !== AW'(16'h0040 + i)) bad = 1;
    tests_run++;
    if (rd_cnt - r0 != VWN || bad) begin
      tests_failed++;
      $display("FAIL v_load_addr: reads=%0d first=%h required 8 reads from 0040", rd_cnt - r0, rd_log[r0%256]);
    end
  endtask

  task automatic run_vstore(input string name, input logic [AW-1:0] base);
    logic [VB-1:0] v;
    logic [AW-1:0] a;
    int w0 = wr_cnt;
    bit bad = 0;
    for (int i = 0; i < VWN; i++) v[i*W +: W] = W'($urandom_range(0, 24'hFFFFFF));
    exp_q.push_back('0);
    exp_vq.push_back('0);
    send_op(1'b1, 1'b0, 1'b1, 1'b0, 4'h3, {8'h00, base}, '0, v, 4'b0011);
    wait_resp(name, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < VWN; i++) begin
      a = base + AW'(i);
      if (wr_log[(w0 + i)%256] !== a || ram[a] !== v[i*W +: W]) bad = 1;
    end
    tests_run++;
    if (wr_cnt - w0 != VWN || bad) begin
      tests_failed++;
      $display("FAIL %s_mem: writes=%0d first=%h lanes_ok=%b required 8 from %h lanes_ok=1",
               name, wr_cnt - w0, wr_log[w0%256], !bad, base);
    end
  endtask

  task automatic test_vector_store();
    run_vstore("v_store_top", 16'hFFF8);
`ifndef VMEM_ALIGN_CHECK_EN
    run_vstore("v_store_wrap", 16'hFFFC);
`endif
  endtask

  task automatic test_reset_mid_access();
    logic [VB-1:0] v;
    int n = 0;
    bit found = 0;
    bit vseen = 0;
    bit bad = 0;
    for (int i = 0; i < VWN; i++) begin
      preload(AW'(16'h0200 + i), 24'hEEEEEE);
      v[i*W +: W] = W'(24'h100000 + i);
    end
    send_op(1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 24'h000200, '0, v, 4'b0000);
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_we_o === 1'b1 && mem_addr_o === 16'h0203) found = 1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL mid_rst_lane3: lane 3 write not seen within %0d cycles", n);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_we_o !== 1'b0 || mem_re_o !== 1'b0 || ready_o !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_rst_ctrl: we=%b re=%b ready=%b valid=%b required 0 0 1 0",
               mem_we_o, mem_re_o, ready_o, valid_o);
    end
    repeat (12) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || mem_we_o !== 1'b0) vseen = 1;
    end
    tests_run++;
    if (vseen) begin
      tests_failed++;
      $display("FAIL mid_rst_quiet: valid_o or mem_we_o rose after reset");
    end
    for (int i = 0; i < VWN; i++) begin
      if (i < 4 && ram[AW'(16'h0200 + i)] !== W'(24'h100000 + i)) bad = 1;
      if (i >= 4 && ram[AW'(16'h0200 + i)] !== 24'hEEEEEE) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL mid_rst_ram: lane3=%h lane4=%h required 100003 EEEEEE",
               ram[16'h0203], ram[16'h0204]);
    end
  endtask

`ifdef VMEM_ALIGN_CHECK_EN
  task automatic test_misaligned();
    int r0 = rd_cnt;
    exp_q.push_back('0);
    exp_vq.push_back('0);
    send_op(1'b1, 1'b1, 1'b0, 1'b1, 4'hC, 24'h000043, '0, '1, 4'b0110);
    wait_resp("misalign", 1, 1'b0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (rd_cnt != r0) begin
      tests_failed++;
      $display("FAIL misalign_noread: reads=%0d required 0", rd_cnt - r0);
    end
  endtask
`endif

  // ---------------- main sequence + report ----------------
  initial begin
    rst = 1'b1; valid_i = 1'b0; is_vector_i = 1'b0; mem_read_i = 1'b0;
    mem_write_i = 1'b0; reg_write_i = 1'b0; rd_i = '0; alu_result_i = '0;
    store_data_i = '0; vec_result_i = '0; flags_i = '0;
    cur_rd = '0; cur_fl = '0; cur_vec = 1'b0;
    test_reset();
    test_alu_back_to_back();
    test_vector_alu();
    test_scalar_store();
    test_scalar_load();
    test_vector_load();
    test_vector_store();
`ifdef VMEM_ALIGN_CHECK_EN
    test_misaligned();
`endif
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
